// File: rtl/adder_driver.sv
// Initiator for the adder's a/b/valid -> c interface: issues operand pairs,
// checks each returned c against a locally computed sum, queues the results.
module adder_driver #(
  parameter int DATA_W     = 4,
  parameter int RES_W      = DATA_W + 1,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              valid,
  input  logic [RES_W-1:0]  c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_sum,
  output logic              out_mismatch,
  output logic [15:0]       err_cnt,
  output logic              busy
);

  localparam int STAGES = ADD_LAT + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + ADD_LAT + 2) + 1;

  logic [STAGES-1:0] tag_live;
  logic [RES_W-1:0]  tag_exp [STAGES];
  logic [RES_W-1:0]  fifo_sum [FIFO_DEPTH];
  logic              fifo_mm [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  credit_used;
  logic [RES_W-1:0]  exp_in;
  logic              accept;
  logic              push;
  logic              pop;
  logic              mismatch;

  // Every issued op reserves a FIFO slot, so a push can never find the FIFO full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflight = inflight + CNT_W'(tag_live[i]);
    end
  end

  assign credit_used  = fifo_count + inflight;
  assign in_ready     = reset && (credit_used < CNT_W'(FIFO_DEPTH));
  assign accept       = in_valid && in_ready;
  assign exp_in       = RES_W'(in_a) + RES_W'(in_b);
  assign push         = tag_live[STAGES-1];
  assign mismatch     = (c != tag_exp[STAGES-1]);
  assign out_valid    = (fifo_count != '0);
  assign pop          = out_valid && out_ready;
  assign out_sum      = fifo_sum[rd_ptr];
  assign out_mismatch = fifo_mm[rd_ptr];
  assign busy         = (inflight != '0) || out_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a          <= '0;
      b          <= '0;
      valid      <= 1'b0;
      tag_live   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      err_cnt    <= '0;
    end else begin
      assert (!(push && fifo_count == CNT_W'(FIFO_DEPTH)));
      valid <= accept;
      if (accept) begin
        a <= in_a;
        b <= in_b;
      end
      tag_live <= {tag_live[STAGES-2:0], accept};
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && mismatch && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  // Datapath storage needs no reset; live bits and pointers qualify it.
  always_ff @(posedge clk) begin
    tag_exp[0] <= exp_in;
    for (int i = 1; i < STAGES; i++) begin
      tag_exp[i] <= tag_exp[i-1];
    end
    if (push) begin
      fifo_sum[wr_ptr] <= c;
      fifo_mm[wr_ptr]  <= mismatch;
    end
  end

endmodule

// File: tb/tb_adder_driver.sv
// Directed bench for adder_driver with a one-cycle adder model that can
// corrupt the result for the (2,2) operand pair.
module tb_adder_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] a;
  logic [3:0] b;
  logic       valid;
  logic [4:0] c = 5'd0;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sum;
  logic       out_mismatch;
  logic [15:0] err_cnt;
  logic       busy;
  logic       inject = 1'b0;

  int checks = 0;
  int failures = 0;
  int acc;
  int exp_q[$];

  adder_driver dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a(a), .b(b), .valid(valid), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_mismatch(out_mismatch), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder model: result appears one cycle after valid.
  always @(posedge clk) begin
    if (valid) c <= (inject && a == 4'd2 && b == 4'd2) ? 5'd5 : ({1'b0, a} + {1'b0, b});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", valid, 0);
    chk("rst_a", a, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single op
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5;
    tick();
    in_valid = 1'b0;
    chk("single_valid", valid, 1);
    chk("single_a", a, 3);
    chk("single_b", b, 5);
    tick();
    chk("single_busy_c2", busy, 1);
    chk("single_outv_c2", out_valid, 0);
    tick();
    chk("single_outv_c3", out_valid, 1);
    chk("single_sum", out_sum, 8);
    chk("single_mm", out_mismatch, 0);
    tick();
    chk("single_busy_c4", busy, 0);

    // Throughput: four pairs back to back, results 2,9,30,0 on cycles 3..6
    begin
      logic [3:0] ta [4] = '{4'd1, 4'd2, 4'd15, 4'd0};
      logic [3:0] tb [4] = '{4'd1, 4'd7, 4'd15, 4'd0};
      logic [4:0] ts [4] = '{5'd2, 5'd9, 5'd30, 5'd0};
      for (int i = 0; i < 8; i++) begin
        in_valid = (i < 4);
        if (i < 4) begin in_a = ta[i]; in_b = tb[i]; end
        tick();
        chk("thr_valid", valid, (i < 4) ? 1 : 0);
        chk("thr_out_valid", out_valid, (i + 1 >= 3 && i + 1 <= 6) ? 1 : 0);
        if (i + 1 >= 3 && i + 1 <= 6) chk("thr_sum", out_sum, ts[i - 2]);
      end
      in_valid = 1'b0;
    end

    // Backpressure: sums 3,5,7,9 then one more (11) after a single pop
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 4'(acc + 1); in_b = 4'(acc + 2);
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepts", acc, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_held", out_sum, 3);
    in_a = 4'(acc + 1); in_b = 4'(acc + 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_head_after_pop", out_sum, 5);
    if (in_ready) acc++;
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready_refull", in_ready, 0);
    tick(); tick(); tick();
    chk("bp_total_accepts", acc, 5);
    out_ready = 1'b1;
    begin
      logic [4:0] bs [4] = '{5'd5, 5'd7, 5'd9, 5'd11};
      for (int k = 0; k < 4; k++) begin
        chk("bp_drain_valid", out_valid, 1);
        chk("bp_drain_sum", out_sum, bs[k]);
        tick();
      end
    end
    chk("bp_drained", out_valid, 0);

    // Mismatch injection
    inject = 1'b1;
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2;
    tick();
    in_a = 4'd4; in_b = 4'd4;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mm_sum", out_sum, 5);
    chk("mm_flag", out_mismatch, 1);
    chk("mm_err_cnt", err_cnt, 1);
    tick();
    chk("ok_sum", out_sum, 8);
    chk("ok_flag", out_mismatch, 0);
    chk("ok_err_cnt", err_cnt, 1);
    tick();
    inject = 1'b0;

    // Reset with one entry queued and two ops in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mr_queued", out_valid, 1);
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
    tick();
    in_a = 4'd4; in_b = 4'd1;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mr_in_ready_rst", in_ready, 0);
    tick();
    chk("mr_out_valid", out_valid, 0);
    chk("mr_valid", valid, 0);
    chk("mr_err_cnt", err_cnt, 0);
    chk("mr_busy", busy, 0);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    chk("mr_in_ready_back", in_ready, 1);
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd8;
    tick();
    in_valid = 1'b0;
    chk("mr_late_c_c1", out_valid, 0);
    tick();
    chk("mr_late_c_c2", out_valid, 0);
    tick();
    chk("mr_first_valid", out_valid, 1);
    chk("mr_first_sum", out_sum, 15);
    chk("mr_first_mm", out_mismatch, 0);
    tick();

    // Push and pop together at occupancy 3, over two pointer laps
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 4'(k + 1); in_b = 4'd0;
      exp_q.push_back(k + 1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 8; k++) begin
      chk("pp_in_ready", in_ready, 1);
      in_valid = 1'b1; in_a = 4'(k + 3); in_b = 4'(2 * k);
      exp_q.push_back(k + 3 + 2 * k);
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b1;
      chk("pp_order", out_sum, exp_q.pop_front());
      tick();
      out_ready = 1'b0;
      chk("pp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("pp_drain_valid", out_valid, 1);
      chk("pp_drain_order", out_sum, exp_q.pop_front());
      tick();
    end
    chk("pp_empty", out_valid, 0);
    chk("pp_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_driver.md
Name: adder_driver

Overview:
- RTL initiator for the adder's a/b/valid → c interface. It drives the adder from the opposite side to the DUT.
- Accepts operand pairs on a valid/ready input stream and issues them to the adder, one per cycle at most.
- Captures c a fixed latency after each issue and checks it against an internally computed sum.
- Returns each result plus a mismatch flag on a valid/ready output stream, through a small result FIFO.

Parameters:
- DATA_W, 4, width of the a, b and in_a, in_b operands.
- RES_W, DATA_W+1, width of adder result c and out_sum.
- ADD_LAT, 1, cycles from the cycle valid is high to the cycle c holds the matching result (ADD_LAT ≥ 1).
- FIFO_DEPTH, 4, number of result FIFO entries (power of 2, ≥ 2).

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  operand pair available
- in_ready  output  1  block accepts the pair this cycle
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- a  output  DATA_W  operand A to adder
- b  output  DATA_W  operand B to adder
- valid  output  1  issue strobe to adder
- c  input  RES_W  adder result
- out_valid  output  1  result entry available
- out_ready  input  1  consumer takes the entry
- out_sum  output  RES_W  captured c
- out_mismatch  output  1  captured c differs from the expected sum
- err_cnt  output  16  saturating mismatch count
- busy  output  1  any op in flight or FIFO not empty

Behaviour:
- Reset: when reset == 0 at a posedge, the block clears:
  - a = 0, b = 0, valid = 0;
  - the in-flight tag pipe;
  - the FIFO (out_valid = 0);
  - err_cnt = 0.
- Reset gating:
  - in_ready is forced to 0 while reset == 0.
  - out_sum and out_mismatch are don't-care while out_valid == 0.
- Credit rule: in_ready = reset && (fifo_count + inflight < FIFO_DEPTH). inflight is the number of issued ops not yet captured. in_ready is combinational from registers only and does not depend on in_valid.
- Issue:
  - On in_valid && in_ready at edge E0, the block registers a ← in_a, b ← in_b, valid ← 1 for cycle 1.
  - Otherwise valid ← 0 and a, b hold their values.
  - Back-to-back issue at 1 op/cycle is allowed.
- Expected sum: exp = zero-extend(in_a) + zero-extend(in_b), truncated to RES_W. It is computed at issue and carried down an ADD_LAT+1 stage tag pipe together with a live bit.
- Capture:
  - A live tag issued in cycle 1 reaches the end of the pipe in cycle 1+ADD_LAT.
  - At that cycle's closing edge, the block pushes {c, c != exp} into the FIFO.
  - c is ignored in cycles with no live tag.
- Latency: out_valid first rises in cycle 2+ADD_LAT after the accept cycle (cycle 3 for ADD_LAT = 1). The FIFO has no bypass.
- FIFO behaviour:
  - out_valid = !empty; out_sum and out_mismatch present the head entry.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop in one cycle: count unchanged, order preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Push-when-full cannot occur because of the credit rule. It is asserted in simulation as an error.
- Output stability: the head entry stays stable while out_valid && !out_ready.
- err_cnt:
  - Increments by 1 on each push with mismatch = 1, and saturates at 0xFFFF.
  - It is not cleared by popping.
- busy = inflight != 0 || !empty.
- Reset mid-operation: all in-flight tags are dropped. Adder results returning after reset are ignored, and FIFO contents are lost. First accept is possible in the cycle after reset returns high.

Test Plan:
- Single op, out_ready = 1:
  - Stimulus: in_a = 3, in_b = 5 accepted at cycle 0; adder returns c = 8.
  - Required: valid = 1 with a = 3, b = 5 in cycle 1; out_valid = 1 with out_sum = 8, out_mismatch = 0 in cycle 3; busy = 0 in cycle 4.
- Throughput, out_ready = 1:
  - Stimulus: four pairs (1,1), (2,7), (15,15), (0,0) accepted in consecutive cycles.
  - Required: valid high 4 consecutive cycles; out_sum sequence 2, 9, 30, 0 on consecutive cycles with no bubbles.
- Backpressure, out_ready = 0, FIFO_DEPTH = 4:
  - Stimulus: in_valid held high.
  - Required: exactly 4 accepts, then in_ready = 0. After out_ready is raised for one pop, in_ready returns to 1 in the next cycle and exactly one more op is accepted. No entry is lost or reordered.
- Mismatch injection:
  - Stimulus: adder model forces c = 5 for in_a = 2, in_b = 2.
  - Required: out_sum = 5, out_mismatch = 1, err_cnt = 1. A following correct op gives out_mismatch = 0 and err_cnt stays 1.
- Reset mid-stream:
  - Stimulus: reset = 0 for one edge while 2 ops are in flight and 1 entry is queued.
  - Required: next cycle out_valid = 0, valid = 0, err_cnt = 0, in_ready = 0 during reset. Late c values produce no FIFO pushes, and the first post-reset op returns a correct result.
- Simultaneous push/pop at FIFO_DEPTH-1 occupancy:
  - Required: count holds, pointers wrap correctly across 2 full laps, and the output order equals the input order.
